// File: rtl/h264_ct_pkg.sv
// rtl/h264_ct_pkg.sv - shared types and constants for the core-transform feeder
//
// Provides the default sample width, the fixed block height, residual
// sample/row/block types and the read-side FSM state encoding.
package h264_ct_pkg;

  localparam int WIDTH_DEF = 9;
  localparam int NROWS     = 4;

  typedef logic signed [WIDTH_DEF-1:0] sample_t;
  // x0 sits in element 0, i.e. the least significant bits of the packed row
  typedef sample_t [3:0]               row_t;
  typedef row_t    [NROWS-1:0]         block_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/h264ct_block_bank.sv
// rtl/h264ct_block_bank.sv - one 4x4 residual storage bank with full flag
//
// Ports:
//   CLK, RESET (sync, active-low), flush (sync clear)
//   i_wr_en / i_wr_row / i_wr_data : row write port
//   i_rd_row / o_rd_data           : combinational row read mux
//   i_set_full / i_clr_full        : full flag control
//   o_full                         : bank holds a complete block
module h264ct_block_bank
  import h264_ct_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               flush,
  input  logic               i_wr_en,
  input  logic [1:0]         i_wr_row,
  input  logic [4*WIDTH-1:0] i_wr_data,
  input  logic [1:0]         i_rd_row,
  output logic [4*WIDTH-1:0] o_rd_data,
  input  logic               i_set_full,
  input  logic               i_clr_full,
  output logic               o_full
);

  logic [4*WIDTH-1:0] r_mem [NROWS];
  logic               r_full;

  // Row storage needs no reset: contents are only ever read while full is set.
  always_ff @(posedge CLK) begin
    if (i_wr_en) begin
      r_mem[i_wr_row] <= i_wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET || flush) begin
      r_full <= 1'b0;
    end else if (i_set_full) begin
      r_full <= 1'b1;
    end else if (i_clr_full) begin
      r_full <= 1'b0;
    end
  end

  // Writes only target an empty bank and reads only drain a full one.
  always_ff @(posedge CLK) begin
    if (RESET && !flush) begin
      assert (!(i_set_full && i_clr_full));
    end
  end

  assign o_rd_data = r_mem[i_rd_row];
  assign o_full    = r_full;

endmodule

// File: rtl/h264coretransform_feeder.sv
// rtl/h264coretransform_feeder.sv - ping-pong 4x4 block buffer feeding the core transform
//
// Ports:
//   CLK, RESET (sync, active-low), flush (sync clear, same effect as RESET)
//   in_valid / in_ready / in_row   : upstream rows, x0 in bits [WIDTH-1:0]
//   out_valid / out_ready / out_row: rows to the core transform
//   out_start                      : row 0 of a block presented (controller ENABLE)
//   out_last                       : row 3 of a block presented
//   blk_count                      : blocks fully delivered, wraps at 16 bits
module h264coretransform_feeder #(
  parameter int WIDTH = 9,
  parameter int NROWS = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] in_row,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WIDTH-1:0] out_row,
  output logic               out_start,
  output logic               out_last,
  output logic [15:0]        blk_count
);
  import h264_ct_pkg::*;

  if (NROWS != 4) begin : g_nrows_check
    $error("h264coretransform_feeder supports NROWS == 4 only");
  end

  rd_state_t          r_state;
  rd_state_t          w_state_nxt;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [1:0]         r_wr_row;
  logic [1:0]         r_rd_row;
  logic [15:0]        r_blk_count;

  logic [1:0]         w_full;
  logic [4*WIDTH-1:0] w_rd_data [2];
  logic               w_wr_fire;
  logic               w_wr_done;
  logic               w_rd_fire;
  logic               w_rd_done;

  assign in_ready  = !w_full[r_wr_bank];
  assign w_wr_fire = in_valid && in_ready;
  assign w_wr_done = w_wr_fire && (r_wr_row == 2'd3);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    h264ct_block_bank #(
      .WIDTH (WIDTH)
    ) u_bank (
      .CLK        (CLK),
      .RESET      (RESET),
      .flush      (flush),
      .i_wr_en    (w_wr_fire && (r_wr_bank == 1'(b))),
      .i_wr_row   (r_wr_row),
      .i_wr_data  (in_row),
      .i_rd_row   (r_rd_row),
      .o_rd_data  (w_rd_data[b]),
      .i_set_full (w_wr_done && (r_wr_bank == 1'(b))),
      .i_clr_full (w_rd_done && (r_rd_bank == 1'(b))),
      .o_full     (w_full[b])
    );
  end

  assign out_row   = w_rd_data[r_rd_bank];
  assign blk_count = r_blk_count;

  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    out_start   = 1'b0;
    out_last    = 1'b0;
    w_rd_fire   = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (w_full[r_rd_bank]) begin
          w_state_nxt = R_STREAM;
        end
      end
      R_STREAM: begin
        out_valid = 1'b1;
        out_start = (r_rd_row == 2'd0);
        out_last  = (r_rd_row == 2'd3);
        w_rd_fire = out_ready;
        w_rd_done = out_ready && (r_rd_row == 2'd3);
        // Other bank already complete: roll straight into it with no bubble.
        if (w_rd_done && !w_full[!r_rd_bank]) begin
          w_state_nxt = R_IDLE;
        end
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // Row counters are 2 bits, so the wrap 3->0 happens on the block boundary.
  always_ff @(posedge CLK) begin
    if (!RESET || flush) begin
      r_state     <= R_IDLE;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_row    <= 2'd0;
      r_rd_row    <= 2'd0;
      r_blk_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_fire) begin
        r_wr_row <= r_wr_row + 2'd1;
        if (w_wr_done) begin
          r_wr_bank <= !r_wr_bank;
        end
      end
      if (w_rd_fire) begin
        r_rd_row <= r_rd_row + 2'd1;
        if (w_rd_done) begin
          r_rd_bank   <= !r_rd_bank;
          r_blk_count <= r_blk_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_h264coretransform_feeder.sv
// tb/tb_h264coretransform_feeder.sv - directed self-checking bench for h264coretransform_feeder
module tb_h264coretransform_feeder;
  import h264_ct_pkg::*;

  localparam int W  = 9;
  localparam int RW = 4 * W;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_row = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_row;
  logic          out_start;
  logic          out_last;
  logic [15:0]   blk_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [RW+1:0] cap_q [$];
  int            cap_cyc [$];
  logic [RW-1:0] exp_q [$];

  logic [RW-1:0] blk_a [4];
  logic [RW-1:0] blk_b [4];
  logic [RW-1:0] blk_c [4];

  h264coretransform_feeder #(
    .WIDTH (W),
    .NROWS (4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_start (out_start),
    .out_last  (out_last),
    .blk_count (blk_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // A row counts as delivered when valid and ready are both high going into the edge.
  always @(negedge CLK) begin
    if (RESET && !flush && out_valid && out_ready) begin
      cap_q.push_back({out_last, out_start, out_row});
      cap_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pk(input int a, input int b, input int c, input int d);
    row_t r;
    r[0] = sample_t'(a);
    r[1] = sample_t'(b);
    r[2] = sample_t'(c);
    r[3] = sample_t'(d);
    return r;
  endfunction

  task automatic do_reset();
    RESET     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
  endtask

  // Call just after a posedge; returns just after the edge that took the row.
  task automatic send_row(input logic [RW-1:0] r);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_row   = r;
    exp_q.push_back(r);
    @(negedge CLK);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 50) chk({tag, "_valid_timeout"}, 64'(n), 64'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_cap(input string tag);
    chk({tag, "_nrows"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      chk($sformatf("%s_row%0d", tag, i), 64'(cap_q[i][RW-1:0]), 64'(exp_q[i]));
      chk($sformatf("%s_start%0d", tag, i), 64'(cap_q[i][RW]), 64'((i % 4) == 0));
      chk($sformatf("%s_last%0d", tag, i), 64'(cap_q[i][RW+1]), 64'((i % 4) == 3));
    end
  endtask

  initial begin
    blk_a[0] = pk(1, 2, 3, 4);
    blk_a[1] = pk(5, 6, 7, 8);
    blk_a[2] = pk(-1, -2, -3, -4);
    blk_a[3] = pk(255, -256, 0, 7);
    blk_b[0] = pk(10, -20, 30, -40);
    blk_b[1] = pk(100, 101, -102, 103);
    blk_b[2] = pk(0, 0, 0, 1);
    blk_b[3] = pk(-128, 127, 64, -64);
    blk_c[0] = pk(11, 12, 13, 14);
    blk_c[1] = pk(-5, 6, -7, 8);
    blk_c[2] = pk(200, -200, 50, -50);
    blk_c[3] = pk(1, -1, 1, -1);

    // Reset state and single block latency.
    do_reset();
    @(negedge CLK);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_start", 64'(out_start), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_blk_count", 64'(blk_count), 64'd0);
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_row(blk_a[i]);
    @(negedge CLK);
    chk("t1_lat_edge_n", 64'(out_valid), 64'd0);
    @(negedge CLK);
    chk("t1_lat_edge_n1", 64'(out_valid), 64'd1);
    chk("t1_first_row", 64'(out_row), 64'(blk_a[0]));
    tick(8);
    check_cap("t1");
    chk("t1_blk_count", 64'(blk_count), 64'd1);
    chk("t1_idle_after", 64'(out_valid), 64'd0);

    // Three blocks back to back.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_row(blk_a[i]);
    for (int i = 0; i < 4; i++) send_row(blk_b[i]);
    for (int i = 0; i < 4; i++) send_row(blk_c[i]);
    tick(20);
    check_cap("t2");
    chk("t2_blk_count", 64'(blk_count), 64'd3);
    if (cap_cyc.size() >= 5) chk("t2_no_gap", 64'(cap_cyc[4] - cap_cyc[3]), 64'd1);

    // Both banks full with the output stalled.
    do_reset();
    for (int i = 0; i < 4; i++) send_row(blk_a[i]);
    for (int i = 0; i < 4; i++) send_row(blk_b[i]);
    @(negedge CLK);
    chk("t3_in_ready_low", 64'(in_ready), 64'd0);
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    chk("t3_hold_row0", 64'(out_row), 64'(blk_a[0]));
    chk("t3_hold_start", 64'(out_start), 64'd1);
    tick(3);
    @(negedge CLK);
    chk("t3_hold_row0_later", 64'(out_row), 64'(blk_a[0]));
    chk("t3_none_taken", 64'(cap_q.size()), 64'd0);
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("t3_in_ready_lo%0d", k), 64'(in_ready), 64'd0);
    end
    @(negedge CLK);
    chk("t3_in_ready_rise", 64'(in_ready), 64'd1);
    tick(8);
    check_cap("t3");
    chk("t3_blk_count", 64'(blk_count), 64'd2);

    // Output ready toggling mid-block.
    do_reset();
    for (int i = 0; i < 4; i++) send_row(blk_b[i]);
    wait_valid("t4");
    @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      out_ready = ((i % 2) == 0);
      @(negedge CLK);
      if ((i % 2) == 1) chk($sformatf("t4_held%0d", i), 64'(out_row), 64'(blk_b[(i + 1) / 2]));
      @(posedge CLK);
      #1;
    end
    out_ready = 1'b0;
    tick(2);
    check_cap("t4");
    chk("t4_blk_count", 64'(blk_count), 64'd1);

    // Flush mid-write, then flush mid-stream.
    do_reset();
    send_row(blk_a[0]);
    send_row(blk_a[1]);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge CLK);
    chk("t5_f1_out_valid", 64'(out_valid), 64'd0);
    chk("t5_f1_in_ready", 64'(in_ready), 64'd1);
    chk("t5_f1_blk_count", 64'(blk_count), 64'd0);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) send_row(blk_b[i]);
    wait_valid("t5");
    chk("t5_b_row0", 64'(out_row), 64'(blk_b[0]));
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0;
    @(negedge CLK);
    chk("t5_b_row2", 64'(out_row), 64'(blk_b[2]));
    chk("t5_pre_blk_count", 64'(blk_count), 64'd0);
    @(posedge CLK);
    #1;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge CLK);
    chk("t5_f2_out_valid", 64'(out_valid), 64'd0);
    chk("t5_f2_out_start", 64'(out_start), 64'd0);
    chk("t5_f2_out_last", 64'(out_last), 64'd0);
    chk("t5_f2_in_ready", 64'(in_ready), 64'd1);
    chk("t5_f2_blk_count", 64'(blk_count), 64'd0);
    @(posedge CLK);
    #1;
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_row(blk_c[i]);
    tick(8);
    check_cap("t5");
    chk("t5_blk_count", 64'(blk_count), 64'd1);

    // Block counter wrap.
    do_reset();
    force dut.r_blk_count = 16'hFFFF;
    @(negedge CLK);
    chk("t6_preload", 64'(blk_count), 64'd65535);
    release dut.r_blk_count;
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_row(blk_a[i]);
    tick(8);
    check_cap("t6");
    chk("t6_wrap", 64'(blk_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
